// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: opcodes, instruction field
// positions and the fetch/issue state encoding.
package seq_pkg;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    HALT
  } seq_state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  // Ops the datapath is known to implement; anything else is still forwarded.
  function automatic logic is_datapath_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ADD) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: owns the PC, reads the ROM, runs HALT/JMP locally and
// hands every other instruction to the datapath. Optional macro: SEQ_SINGLE_STEP_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int AW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [AW-1:0]    rom_addr,
  input  logic [31:0]      rom_data,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  input  logic             issue_ready,
  output logic [AW-1:0]    pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] issued_cnt
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic             step
`endif
);

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;

  seq_state_e       state_q;
  logic [AW-1:0]    pc_q;
  logic [31:0]      ir_q;
  logic             issue_valid_q;
  logic [31:0]      issue_instr_q;
  logic             running_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [AW-1:0]    pc_inc_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [3:0]       opcode;
  logic [AW-1:0]    jmp_target;
  logic             advance;

  // Reset asserts immediately but releases two clocks after rst_n rises, so
  // every flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign opcode     = opcode_of(ir_q);
  assign jmp_target = ir_q[AW-1:0];
  assign pc_inc_d   = pc_q + AW'(1);
  assign cnt_inc_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      ir_q          <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
            state_q   <= FETCH;
          end
        end

        FETCH: begin
          ir_q    <= rom_data;
          state_q <= DECODE;
        end

        // HALT is recognised even while single-step holds DECODE.
        DECODE: begin
          if (opcode == OP_HALT) begin
            running_q <= 1'b0;
            halted_q  <= 1'b1;
            state_q   <= HALT;
          end else if (advance) begin
            if (opcode == OP_JMP) begin
              pc_q    <= jmp_target;
              state_q <= FETCH;
            end else begin
              issue_valid_q <= 1'b1;
              issue_instr_q <= ir_q;
              state_q       <= ISSUE;
            end
          end
        end

        // issue_instr is left untouched after the handshake; only valid drops.
        ISSUE: begin
          if (issue_ready) begin
            issue_valid_q <= 1'b0;
            pc_q          <= pc_inc_d;
            cnt_q         <= cnt_inc_d;
            state_q       <= FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign issue_valid = issue_valid_q;
  assign issue_instr = issue_instr_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a program walker predicts the issue
// stream into a queue and a monitor compares each datapath handshake against it.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int AW    = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    rom_addr;
  logic [31:0]      rom_data;
  logic             issue_valid;
  logic [31:0]      issue_instr;
  logic             issue_ready = 1'b0;
  logic [AW-1:0]    pc;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] issued_cnt;
`ifdef SEQ_SINGLE_STEP_EN
  logic             step = 1'b1;
`endif

  logic [31:0] rom [8];
  assign rom_data = rom[rom_addr];

  instr_sequencer #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .pc          (pc),
    .running     (running),
    .halted      (halted),
    .issued_cnt  (issued_cnt)
`ifdef SEQ_SINGLE_STEP_EN
    ,
    .step        (step)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    int            cnt;
    int            t;
    bit            chk;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            ready_mode = 0;
  bit            exp_halts;
  logic [AW-1:0] exp_pc;
  int            exp_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Walk the program by its architectural rules: forwarded ops take three
  // cycles and are issued, JMP takes two, HALT stops the walk.
  task automatic build_model(input bit chk_time);
    int p, t, n;
    logic [31:0] w;
    p = 0; t = 0; n = 0;
    exp_q.delete();
    exp_halts = 1'b0;
    for (int s = 0; s < 200; s++) begin
      w = rom[p];
      if (w[31:28] == OP_HALT) begin
        exp_halts = 1'b1;
        break;
      end else if (w[31:28] == OP_JMP) begin
        p = int'(w[AW-1:0]);
        t += 2;
      end else begin
        t += 3;
        exp_q.push_back('{pc: AW'(p), instr: w, cnt: n, t: start_cyc + t, chk: chk_time});
        n++;
        p = (p + 1) % 8;
        if (n >= 64) break;
      end
    end
    exp_pc = AW'(p);
    exp_n  = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       issue_ready = 1'b1;
      1:       issue_ready = 1'($urandom_range(0, 1));
      default: issue_ready = 1'b0;
    endcase
  endtask

  task automatic start_prog(input int mode, input bit chk_time);
    ready_mode = mode;
    start_cyc  = cyc + 1;
    build_model(chk_time);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input bit rand_start);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      if (rand_start && running && ($urandom_range(0, 15) == 0)) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("halted", halted, 1);
    check("running_at_halt", running, 0);
    check("pc_at_halt", pc, exp_pc);
    check("cnt_at_halt", issued_cnt, exp_n);
    check("all_expected_issued", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", issue_valid, 0);
    check("rst_instr", issue_instr, 0);
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", issued_cnt, 0);
    exp_q.delete();
    start = 1'b0;
    ready_mode = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic load_basic();
    foreach (rom[a]) rom[a] = 32'h0000_0000;
    rom[0] = 32'h1100_0014;
    rom[1] = 32'h1200_0020;
    rom[2] = 32'h2120_0000;
    rom[3] = 32'hF100_0000;
  endtask

  // Monitor: pops one prediction per handshake and checks hold-while-stalled.
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [31:0]   prev_instr;
  logic [AW-1:0] prev_pc;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_valid && !prev_hs) begin
        check("hold_valid", issue_valid, 1);
        check("hold_instr", issue_instr, prev_instr);
        check("hold_pc", pc, prev_pc);
      end
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", issue_instr, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("issue_instr", issue_instr, e.instr);
          check("issue_pc", pc, e.pc);
          check("issue_cnt_before", issued_cnt, e.cnt);
          if (e.chk) check("issue_cycle", cyc + 1, e.t);
        end
      end
      prev_valid = issue_valid;
      prev_hs    = issue_valid && issue_ready;
      prev_instr = issue_instr;
      prev_pc    = pc;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          mode, r;
    logic [3:0]  op;

    foreach (rom[a]) rom[a] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("init_valid", issue_valid, 0);
    check("init_instr", issue_instr, 0);
    check("init_pc", pc, 0);
    check("init_running", running, 0);
    check("init_halted", halted, 0);
    check("init_cnt", issued_cnt, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic program, ready tied high: issues on cycles 3,6,9,12.
    load_basic();
    start_prog(0, 1'b1);
    wait_halt(100, 1'b0);

    // Same program restarted from HALT with a 5-cycle stall on the first issue.
    start_prog(2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) break;
      tick();
    end
    check("stall_valid_seen", issue_valid, 1);
    repeat (5) begin
      tick();
      check("stall_valid", issue_valid, 1);
      check("stall_instr", issue_instr, 32'h1100_0014);
      check("stall_pc", pc, 0);
      check("stall_cnt", issued_cnt, 0);
    end
    ready_mode = 0;
    tick();
    tick();
    check("after_stall_cnt", issued_cnt, 1);
    check("after_stall_pc", pc, 1);
    wait_halt(100, 1'b0);

    // Jump over words 3..5.
    foreach (rom[a]) rom[a] = 32'h0;
    rom[0] = 32'h1100_0014;
    rom[1] = 32'h1200_0020;
    rom[2] = 32'h3000_0006;
    rom[6] = 32'hF100_0000;
    rom[7] = 32'h0000_0000;
    start_prog(0, 1'b1);
    wait_halt(100, 1'b0);

    // Eight forwarded words: the PC wraps 7->0.
    foreach (rom[a]) rom[a] = 32'h1000_0000 + 32'(a);
    start_prog(0, 1'b1);
    repeat (27) tick();
    check("wrap_cnt", issued_cnt, 9);
    check("wrap_pc", pc, 1);
    check("wrap_running", running, 1);

    // Reset in the middle of a stalled issue, then re-run from zero.
    ready_mode = 2;
    for (int i = 0; i < 10; i++) begin
      if (issue_valid) break;
      tick();
    end
    check("pre_reset_valid", issue_valid, 1);
    apply_reset();
    load_basic();
    start_prog(0, 1'b1);
    wait_halt(100, 1'b0);

    // A jump to itself spins forever without issuing.
    foreach (rom[a]) rom[a] = 32'h0;
    rom[0] = 32'h3000_0000;
    start_prog(0, 1'b1);
    repeat (20) tick();
    check("selfjmp_running", running, 1);
    check("selfjmp_halted", halted, 0);
    check("selfjmp_cnt", issued_cnt, 0);
    check("selfjmp_pc", pc, 0);
    apply_reset();

    // Random programs with random backpressure and ignored start pulses.
    for (int k = 0; k < 24; k++) begin
      for (int a = 0; a < 8; a++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) op = OP_HALT;
        else if (r <= 2) op = OP_JMP;
        else begin
          op = 4'($urandom_range(1, 15));
          if (op == OP_JMP) op = OP_OUT;
        end
        rom[a] = {op, 28'($urandom)};
      end
      mode = int'($urandom_range(0, 1));
      start_prog(mode, mode == 0);
      if (exp_halts) begin
        wait_halt(400, 1'b1);
      end else begin
        repeat (60) tick();
        check("loop_running", running, 1);
        check("loop_halted", halted, 0);
        apply_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
